// File: rtl/store_narrow.sv
// Sub-word store unit: read-modify-write of one word in a word-wide memory.
// Word stores write directly; byte/halfword stores read, merge one lane, and write back.
module sn_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] old_v,
  input  logic [VEC_W-1:0] new_v,
  output logic [VEC_W-1:0] q
);
  assign q = sel ? new_v : old_v;
endmodule

module store_narrow #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ready,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [1:0]        SOp,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE, ERR} st_t;

  st_t         st, ns;
  logic [1:0]  a_lo;
  logic [15:0] wd_q;
  logic [1:0]  sop_q;
  logic        bad;
  logic        acc;

  logic [NUM_LANES-1:0][VEC_W-1:0] old_l, new_l, mrg_l;
  logic [NUM_LANES-1:0]            lsel;

  // Upper address bits are intentionally dropped; memory aliases across them.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2]};

  assign bad = (SOp == 2'd3) ||
               (SOp == 2'd1 && addr[0]) ||
               (SOp == 2'd0 && addr[1:0] != 2'b00);
  assign acc = (st == IDLE) && req;

  always_comb begin
    ns = st;
    case (st)
      IDLE:    if (req) ns = bad ? ERR : (SOp == 2'd0 ? WR : RD);
      RD:      ns = MERGE;
      MERGE:   ns = WR;
      WR:      ns = DONE;
      DONE:    ns = IDLE;
      ERR:     ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  assign old_l = mem_rdata;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LI = i;
      // Byte store hits one lane; halfword store hits the pair sharing addr[1].
      assign lsel[i]  = (sop_q == 2'd2) ? (a_lo == LI) : (a_lo[1] == LI[1]);
      assign new_l[i] = (sop_q == 2'd2) ? wd_q[7:0] : wd_q[8*(i%2) +: 8];
      sn_lane #(.VEC_W(VEC_W)) u_lane (
        .sel  (lsel[i]),
        .old_v(old_l[i]),
        .new_v(new_l[i]),
        .q    (mrg_l[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      a_lo      <= '0;
      wd_q      <= '0;
      sop_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      st <= ns;
      if (acc) begin
        a_lo  <= addr[1:0];
        wd_q  <= wdata[15:0];
        sop_q <= SOp;
        // Memory-facing registers only move for requests that will use them.
        if (!bad) begin
          mem_addr <= addr[ADDR_W+1:2];
          if (SOp == 2'd0) mem_wdata <= wdata;
        end
      end
      if (st == MERGE) mem_wdata <= mrg_l;
    end
  end

  assign ready  = (st == IDLE);
  assign mem_rd = (st == RD);
  assign mem_we = (st == WR);
  assign done   = (st == DONE);
  assign err    = (st == ERR);
endmodule
